// File: rtl/bench_initiator.sv
// bench_initiator: host-CPU stand-in that runs one PCIe benchmark loop over the register and F2C interfaces
module bench_initiator #(
    parameter int CHAN_NBITS      = 7,
    parameter int SINGLE_REG_CHAN = 0,
    parameter int TIMER_CHAN      = 1,
    parameter int F2C_QWORDS      = 16,
    parameter int C2F_DWORDS      = 32,
    parameter int TIMEOUT         = 65535
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic                  singleReg_in,
    output logic [CHAN_NBITS-1:0] cpuChan_out,
    output logic [31:0]           cpuWrData_out,
    output logic                  cpuWrValid_out,
    input  logic                  cpuWrReady_in,
    input  logic [31:0]           cpuRdData_in,
    input  logic                  cpuRdValid_in,
    output logic                  cpuRdReady_out,
    input  logic [63:0]           f2cData_in,
    input  logic                  f2cValid_in,
    output logic                  f2cReady_out,
    output logic [31:0]           result_out,
    output logic                  resultValid_out,
    output logic [63:0]           checksum_out,
    output logic                  busy_out,
    output logic                  error_out
);
    localparam int QW_W = F2C_QWORDS > 1 ? $clog2(F2C_QWORDS) : 1;
    localparam int DW_W = C2F_DWORDS > 1 ? $clog2(C2F_DWORDS) : 1;
    localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_KICK, S_DRAIN, S_REPLY, S_READ} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [QW_W-1:0]       qw_q, qw_d;
    logic [DW_W-1:0]       dw_q, dw_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [63:0]           checksum_q, checksum_d;
    logic [31:0]           result_q, result_d;
    logic                  rv_q, rv_d;
    logic                  err_q, err_d;
    logic [CHAN_NBITS-1:0] chan_q, chan_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  f2c_ready_q, f2c_ready_d;
    logic                  busy_q, busy_d;
    logic                  wr_hs, rd_hs, f2c_hs, hs, timeout;

    assign wr_hs   = wr_valid_q & cpuWrReady_in;
    assign rd_hs   = rd_ready_q & cpuRdValid_in;
    assign f2c_hs  = f2c_ready_q & f2cValid_in;
    assign hs      = wr_hs | rd_hs | f2c_hs;
    assign timeout = state_q != S_IDLE && !hs && wd_q == WD_W'(TIMEOUT - 1);

    assign cpuChan_out     = chan_q;
    assign cpuWrData_out   = wdata_q;
    assign cpuWrValid_out  = wr_valid_q;
    assign cpuRdReady_out  = rd_ready_q;
    assign f2cReady_out    = f2c_ready_q;
    assign result_out      = result_q;
    assign resultValid_out = rv_q;
    assign checksum_out    = checksum_q;
    assign busy_out        = busy_q;
    assign error_out       = err_q;

    // next state plus every output precomputed from it so all outputs leave flops with no bubble
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        qw_d       = qw_q;
        dw_d       = dw_q;
        checksum_d = checksum_q;
        result_d   = result_q;
        rv_d       = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: if (start_in) begin
                state_d    = S_CFG;
                mode_d     = singleReg_in;
                err_d      = 1'b0;
                checksum_d = '0;
            end
            S_CFG: if (wr_hs) state_d = S_KICK;
            S_KICK: if (wr_hs) begin
                state_d = S_DRAIN;
                qw_d    = QW_W'(F2C_QWORDS - 1);
            end
            S_DRAIN: if (f2c_hs) begin
                checksum_d = checksum_q ^ f2cData_in;
                qw_d       = qw_q == '0 ? qw_q : qw_q - 1'b1;
                if (qw_q == '0) begin
                    state_d = S_REPLY;
                    dw_d    = mode_q ? '0 : DW_W'(C2F_DWORDS - 1);
                end
            end
            S_REPLY: if (wr_hs) begin
                state_d = dw_q == '0 ? S_READ : S_REPLY;
                dw_d    = dw_q == '0 ? dw_q : dw_q - 1'b1;
            end
            S_READ: if (rd_hs) begin
                state_d  = S_IDLE;
                result_d = cpuRdData_in;
                rv_d     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
        wd_d        = (state_q == S_IDLE || hs || state_d != state_q) ? '0 : wd_q + 1'b1;
        wr_valid_d  = state_d inside {S_CFG, S_KICK, S_REPLY};
        rd_ready_d  = state_d == S_READ;
        f2c_ready_d = state_d == S_DRAIN;
        busy_d      = state_d != S_IDLE;
        chan_d      = state_d == S_CFG ? CHAN_NBITS'(SINGLE_REG_CHAN) :
                      state_d == S_IDLE ? chan_q : CHAN_NBITS'(TIMER_CHAN);
        wdata_d     = state_d == S_CFG ? {31'b0, mode_d} :
                      (state_d == S_REPLY && state_q == S_REPLY) ? wdata_q + 32'(wr_hs) :
                      state_d inside {S_KICK, S_REPLY} ? '0 : wdata_q;
    end

    // state and output registers; reset aborts any run in flight
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            qw_q        <= '0;
            dw_q        <= '0;
            wd_q        <= '0;
            checksum_q  <= '0;
            result_q    <= '0;
            rv_q        <= 1'b0;
            err_q       <= 1'b0;
            chan_q      <= '0;
            wdata_q     <= '0;
            wr_valid_q  <= 1'b0;
            rd_ready_q  <= 1'b0;
            f2c_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            qw_q        <= qw_d;
            dw_q        <= dw_d;
            wd_q        <= wd_d;
            checksum_q  <= checksum_d;
            result_q    <= result_d;
            rv_q        <= rv_d;
            err_q       <= err_d;
            chan_q      <= chan_d;
            wdata_q     <= wdata_d;
            wr_valid_q  <= wr_valid_d;
            rd_ready_q  <= rd_ready_d;
            f2c_ready_q <= f2c_ready_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_bench_initiator.sv
// tb_bench_initiator: scoreboard bench for bench_initiator with responders for writes, reads and the F2C stream
module tb_bench_initiator;
    localparam int CW = 7;
    localparam int QW = 16;
    localparam int DW = 32;
    localparam int TO = 100;
    localparam logic [CW-1:0] CH_CFG = 7'd0;
    localparam logic [CW-1:0] CH_TMR = 7'd1;

    logic          clk_in = 1'b0;
    logic          reset_in, start_in, singleReg_in;
    logic [CW-1:0] cpuChan_out;
    logic [31:0]   cpuWrData_out, cpuRdData_in, result_out;
    logic          cpuWrValid_out, cpuWrReady_in, cpuRdValid_in, cpuRdReady_out;
    logic [63:0]   f2cData_in, checksum_out;
    logic          f2cValid_in, f2cReady_out, resultValid_out, busy_out, error_out;

    int total = 0, bad = 0;
    int wr_cnt = 0, qw_cnt = 0, rv_cnt = 0, cyc = 0, last_fire = 0, err_cyc = 0;
    int w0, q0, r0;
    int wr_delay = 0, f2c_limit = 16, run_id = 0;
    bit f2c_gap = 0;
    logic [31:0] rd_value = '0;
    logic [CW+31:0] exp_wr[$];
    logic [31:0]    exp_res[$];

    bench_initiator #(.TIMEOUT(TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .singleReg_in(singleReg_in),
        .cpuChan_out(cpuChan_out), .cpuWrData_out(cpuWrData_out), .cpuWrValid_out(cpuWrValid_out),
        .cpuWrReady_in(cpuWrReady_in), .cpuRdData_in(cpuRdData_in), .cpuRdValid_in(cpuRdValid_in),
        .cpuRdReady_out(cpuRdReady_out), .f2cData_in(f2cData_in), .f2cValid_in(f2cValid_in),
        .f2cReady_out(f2cReady_out), .result_out(result_out), .resultValid_out(resultValid_out),
        .checksum_out(checksum_out), .busy_out(busy_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // responders: write-ready after wr_delay stall cycles, F2C source 1,2,3.., read returns rd_value
    initial begin
        bit w, f, tog;
        int sent, wwait, seen;
        tog = 0; sent = 0; wwait = 0; seen = 0;
        cpuWrReady_in = 0; f2cValid_in = 0; f2cData_in = '0; cpuRdValid_in = 0; cpuRdData_in = '0;
        forever begin
            @(negedge clk_in);
            w = cpuWrValid_out && cpuWrReady_in && !reset_in;
            f = f2cValid_in && f2cReady_out && !reset_in;
            @(posedge clk_in);
            #1;
            if (f) sent++;
            if (seen != run_id) begin
                seen = run_id;
                sent = 0;
            end
            if (w) wwait = 0;
            if (cpuWrValid_out) begin
                cpuWrReady_in = wwait >= wr_delay;
                wwait++;
            end else begin
                cpuWrReady_in = 0;
                wwait = 0;
            end
            tog = !tog;
            f2cValid_in = sent < f2c_limit && (!f2c_gap || tog);
            f2cData_in = 64'(sent + 1);
            cpuRdValid_in = cpuRdReady_out;
            cpuRdData_in = rd_value;
        end
    end

    // monitor: pops the scoreboard on every write and result, checks hold and exclusivity
    initial begin
        bit w, f, r, prev_stall, prev_err;
        logic [CW-1:0] pchan;
        logic [31:0] pdata;
        logic [CW+31:0] e;
        prev_stall = 0; prev_err = 0; pchan = '0; pdata = '0;
        forever begin
            @(negedge clk_in);
            cyc++;
            w = cpuWrValid_out && cpuWrReady_in && !reset_in;
            f = f2cValid_in && f2cReady_out && !reset_in;
            r = cpuRdReady_out && cpuRdValid_in && !reset_in;
            chk("exclusive", 64'(int'(cpuWrValid_out) + int'(cpuRdReady_out) + int'(f2cReady_out) <= 1), 64'd1);
            if (prev_stall && cpuWrValid_out) begin
                chk("hold_chan", cpuChan_out, pchan);
                chk("hold_data", cpuWrData_out, pdata);
            end
            prev_stall = cpuWrValid_out && !cpuWrReady_in && !reset_in;
            pchan = cpuChan_out;
            pdata = cpuWrData_out;
            if (w) begin
                wr_cnt++;
                last_fire = cyc;
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got chan 0x%0h data 0x%0h, expected no write", cpuChan_out, cpuWrData_out);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_chan", cpuChan_out, e[CW+31:32]);
                    chk("wr_data", cpuWrData_out, e[31:0]);
                end
            end
            if (f || r) last_fire = cyc;
            if (f) qw_cnt++;
            if (resultValid_out) begin
                rv_cnt++;
                if (exp_res.size() == 0) begin
                    total++; bad++;
                    $display("FAIL result_unexpected: got 0x%0h, expected no result", result_out);
                end else chk("result", result_out, exp_res.pop_front());
            end
            if (error_out && !prev_err) err_cyc = cyc;
            prev_err = error_out;
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_wr_valid"}, cpuWrValid_out, 0);
        chk({nm, "_rd_ready"}, cpuRdReady_out, 0);
        chk({nm, "_f2c_ready"}, f2cReady_out, 0);
        chk({nm, "_res_valid"}, resultValid_out, 0);
        chk({nm, "_busy"}, busy_out, 0);
        chk({nm, "_error"}, error_out, 0);
        chk({nm, "_result"}, result_out, 0);
        chk({nm, "_checksum"}, checksum_out, 0);
        chk({nm, "_chan"}, cpuChan_out, 0);
        chk({nm, "_wr_data"}, cpuWrData_out, 0);
    endtask

    task automatic run(input bit mode, input logic [31:0] rd, input int dly, input bit gap, input int lim);
        @(posedge clk_in);
        #1;
        singleReg_in = mode; rd_value = rd; wr_delay = dly; f2c_gap = gap; f2c_limit = lim; run_id++;
        exp_wr.push_back({CH_CFG, 31'b0, mode});
        exp_wr.push_back({CH_TMR, 32'd0});
        if (lim >= QW) begin
            for (int i = 0; i < (mode ? 1 : DW); i++) exp_wr.push_back({CH_TMR, 32'(i)});
            exp_res.push_back(rd);
        end
        w0 = wr_cnt; q0 = qw_cnt; r0 = rv_cnt;
        @(posedge clk_in);
        #1 start_in = 1;
        @(posedge clk_in);
        #1 start_in = 0;
        singleReg_in = !mode;
        @(negedge clk_in);
        chk("start_busy", busy_out, 1);
        chk("start_err_clear", error_out, 0);
        repeat (5) @(posedge clk_in);
        #1 start_in = 1;
        @(posedge clk_in);
        #1 start_in = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy_out && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_finish_in_time"}, 64'(n < 3000), 1);
        @(negedge clk_in);
    endtask

    task automatic check_run(input string nm, input int wr, input int qw, input int rv, input logic [63:0] cs, input bit err);
        chk({nm, "_writes"}, 64'(wr_cnt - w0), 64'(wr));
        chk({nm, "_qwords"}, 64'(qw_cnt - q0), 64'(qw));
        chk({nm, "_results"}, 64'(rv_cnt - r0), 64'(rv));
        chk({nm, "_checksum"}, checksum_out, cs);
        chk({nm, "_error"}, error_out, err);
        chk({nm, "_busy"}, busy_out, 0);
        chk({nm, "_wr_left"}, 64'(exp_wr.size()), 0);
        chk({nm, "_res_left"}, 64'(exp_res.size()), 0);
    endtask

    initial begin
        reset_in = 1; start_in = 0; singleReg_in = 0;
        repeat (2) @(posedge clk_in);
        #1 reset_in = 0;
        @(negedge clk_in);
        check_reset("reset");

        run(0, 32'h0000_1234, 0, 0, QW);
        wait_idle("mode0");
        check_run("mode0", 2 + DW, QW, 1, 64'h10, 0);
        chk("mode0_result_hold", result_out, 32'h1234);

        run(1, 32'hABCD_0001, 0, 0, QW);
        wait_idle("mode1");
        check_run("mode1", 3, QW, 1, 64'h10, 0);

        run(0, 32'h5555_AAAA, 3, 1, QW);
        wait_idle("stall");
        check_run("stall", 2 + DW, QW, 1, 64'h10, 0);

        run(0, 32'h0000_0BAD, 0, 0, 5);
        wait_idle("timeout");
        check_run("timeout", 2, 5, 0, 64'h1, 1);
        chk("timeout_latency", 64'(err_cyc - last_fire), 64'(TO + 1));
        chk("timeout_f2c_ready", f2cReady_out, 0);
        chk("timeout_wr_valid", cpuWrValid_out, 0);

        run(0, 32'h0000_7777, 0, 0, QW);
        wait_idle("after_to");
        check_run("after_to", 2 + DW, QW, 1, 64'h10, 0);

        run(0, 32'h0000_9999, 0, 0, QW);
        for (int i = 0; i < 500 && wr_cnt < w0 + 12; i++) begin
            @(posedge clk_in);
            #1;
        end
        reset_in = 1;
        @(posedge clk_in);
        #1 reset_in = 0;
        exp_wr.delete();
        exp_res.delete();
        @(negedge clk_in);
        check_reset("midreset");
        chk("midreset_writes", 64'(wr_cnt - w0), 12);
        repeat (20) @(negedge clk_in);
        chk("midreset_quiet_writes", 64'(wr_cnt - w0), 12);
        chk("midreset_no_result", 64'(rv_cnt - r0), 0);

        run(0, 32'hCAFE_F00D, 0, 0, QW);
        wait_idle("fresh");
        check_run("fresh", 2 + DW, QW, 1, 64'h10, 0);
        chk("fresh_result", result_out, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bench_initiator.md
Name: bench_initiator

Overview:
- Hardware stand-in for the host CPU in the PCIe benchmark loop. It is the initiator on the internal register interface and the sink of the FPGA->CPU stream.
- Sequence per run: configure the single-register-reply mode, write the timer register to start a run, drain one F2C chunk, send the CPU->FPGA register-style reply, then read back the timer.
- Used for on-chip self-test and simulation of the benchmark app without a host. It connects directly to the app's cpuChan/cpuWr*/cpuRd*/f2c* signals.

Parameters:
- CHAN_NBITS, 7, width of the register channel number.
- SINGLE_REG_CHAN, 0, channel number of the single-register-reply mode register.
- TIMER_CHAN, 1, channel number of the benchmark timer register.
- F2C_QWORDS, 16, 64-bit words per F2C chunk (≥1).
- C2F_DWORDS, 32, 32-bit register writes in a multi-register reply (≥1).
- TIMEOUT, 65535, cycles without handshake progress before abort (≥1).

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  synchronous reset, active-high.
- start_in  in  1  one-cycle start pulse.
- singleReg_in  in  1  reply mode, sampled on start: 1 = one reply write, 0 = C2F_DWORDS writes.
- cpuChan_out  out  CHAN_NBITS  register channel for the current write or read.
- cpuWrData_out  out  32  register write data.
- cpuWrValid_out  out  1  write request valid.
- cpuWrReady_in  in  1  write accepted.
- cpuRdData_in  in  32  register read data.
- cpuRdValid_in  in  1  read data valid.
- cpuRdReady_out  out  1  read request.
- f2cData_in  in  64  F2C stream data.
- f2cValid_in  in  1  F2C data valid.
- f2cReady_out  out  1  F2C accept.
- result_out  out  32  timer value from the last completed run.
- resultValid_out  out  1  one-cycle pulse when result_out updates.
- checksum_out  out  64  XOR of all qwords drained in the current or last run.
- busy_out  out  1  high while not in S_IDLE.
- error_out  out  1  sticky timeout flag; cleared on the next accepted start.

Behaviour:
- Reset (synchronous, overrides everything):
  - state = S_IDLE.
  - All valid/ready/pulse outputs = 0; busy_out = 0; error_out = 0.
  - result_out = 0; checksum_out = 0; cpuChan_out = 0; cpuWrData_out = 0.
  - Applies mid-run: no further handshakes occur after the reset edge.
- Handshakes:
  - A write transfers on a cycle where cpuWrValid_out && cpuWrReady_in.
  - cpuChan_out and cpuWrData_out are held stable while cpuWrValid_out && !cpuWrReady_in.
  - A read completes on a cycle where cpuRdReady_out && cpuRdValid_in.
  - An F2C qword transfers on a cycle where f2cValid_in && f2cReady_out.
- S_IDLE:
  - start_in → latch singleReg_in, clear error_out and checksum_out, go to S_CFG.
  - start_in is ignored in every other state.
- S_CFG: cpuWrValid_out = 1, chan = SINGLE_REG_CHAN, data = {31'b0, mode}. On transfer → S_KICK.
- S_KICK: cpuWrValid_out = 1, chan = TIMER_CHAN, data = 0. On transfer → S_DRAIN, qwCount = F2C_QWORDS-1.
- S_DRAIN:
  - f2cReady_out = 1.
  - Each transfer: checksum ^= f2cData_in; qwCount decrements.
  - Transfer with qwCount == 0 → S_REPLY, dwCount = mode ? 0 : C2F_DWORDS-1.
- S_REPLY:
  - cpuWrValid_out = 1, chan = TIMER_CHAN, data = dword index (0, 1, 2, …).
  - Transfer with dwCount == 0 → S_READ; otherwise dwCount decrements.
- S_READ:
  - cpuRdReady_out = 1, chan = TIMER_CHAN.
  - On completion: result_out = cpuRdData_in, resultValid_out = 1 on the next cycle, → S_IDLE.
- Never more than one of cpuWrValid_out, cpuRdReady_out, f2cReady_out is high in any cycle.
- Registered outputs: all outputs come from registers. A state reacts to a handshake on the cycle after it occurs, with no bubble: the next request is asserted on the cycle following the transfer.
- Watchdog:
  - A counter resets on every handshake and on entry to each state, and increments in all states except S_IDLE.
  - When it reaches TIMEOUT: error_out = 1, all valid/ready outputs drop on the next cycle, state → S_IDLE, no result pulse. This deliberately violates valid-hold; it is the abort path only.
- Counter widths: qwCount is $clog2(F2C_QWORDS) bits (minimum 1); dwCount is $clog2(C2F_DWORDS) bits (minimum 1); decrement wraps modulo width but never runs past 0.
- Simultaneous events: a handshake on the same cycle the watchdog would fire counts as progress; no timeout.

Test Plan:
- Default params, mode = 0, responder always ready, F2C stream 1, 2, …, 16, timer read returns 0x0000_1234 → 1 CFG write (data 0), 1 KICK write (data 0), 16 qwords drained, checksum_out = 0x10, 32 reply writes with data 0..31, result_out = 0x1234 with a single resultValid pulse, busy_out low afterwards.
- mode = 1 → exactly one reply write (data 0) before the read; CFG write data = 1.
- f2cValid_in toggled every other cycle and cpuWrReady_in delayed 3 cycles per write → cpuChan/cpuWrData stable during stalls; no lost or duplicated transfers; same counts as the first scenario.
- TIMEOUT = 100, F2C stream stops after 5 qwords → error_out = 1 at exactly 100 idle cycles; f2cReady_out low; state S_IDLE; no resultValid pulse. A new start clears error_out.
- reset_in pulsed mid-S_REPLY (after 10 writes) → all outputs at reset values the next cycle; start pulses during busy are ignored; a fresh run completes normally.
